// File: rtl/nibble_unpack_fifo.sv
// Width-down FIFO: stores bytes and hands them back as nibbles, two pops per byte.
// Define NIBBLE_MSB_FIRST_EN to emit the high nibble of each byte first.
module nibble_unpack_fifo #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        Data_In,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [3:0]        Data_Out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   logic [7:0]        ram [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [ADDR_W:0]   count_reg, count_next;
   logic              nib_sel_reg, nib_sel_next;
   logic              wr_en, pop, byte_done;
   logic [7:0]        cur_byte;
   logic [3:0]        first_nib, second_nib;

   assign full      = (count_reg == DEPTH_C);
   assign empty     = (count_reg == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign count     = count_reg;

   assign wr_en     = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign byte_done = pop && nib_sel_reg;

   assign cur_byte = ram[rd_ptr_reg];

`ifdef NIBBLE_MSB_FIRST_EN
   assign first_nib  = cur_byte[7:4];
   assign second_nib = cur_byte[3:0];
`else
   assign first_nib  = cur_byte[3:0];
   assign second_nib = cur_byte[7:4];
`endif

   // Empty forces zero so stale storage never leaks onto the nibble bus.
   assign Data_Out = empty ? 4'h0 : (nib_sel_reg ? second_nib : first_nib);

   always_comb begin
      wr_ptr_next  = wr_ptr_reg;
      rd_ptr_next  = rd_ptr_reg;
      count_next   = count_reg;
      nib_sel_next = nib_sel_reg;

      if (wr_en)
         wr_ptr_next = wr_ptr_reg + ADDR_W'(1);

      if (pop) begin
         nib_sel_next = !nib_sel_reg;
         if (nib_sel_reg)
            rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
      end

      case ({wr_en, byte_done})
         2'b10:   count_next = count_reg + (ADDR_W+1)'(1);
         2'b01:   count_next = count_reg - (ADDR_W+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         nib_sel_reg <= 1'b0;
      end else begin
         wr_ptr_reg  <= wr_ptr_next;
         rd_ptr_reg  <= rd_ptr_next;
         count_reg   <= count_next;
         nib_sel_reg <= nib_sel_next;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en)
         ram[wr_ptr_reg] <= Data_In;
   end

endmodule
